// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch queue: up to DEPTH sram-like fetches in flight, in-order return buffer.
// Redirect discards queued entries and drops data of fetches still in flight.
module inst_prefetch_queue #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'hbfc00000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic        out_valid,
   output logic [31:0] out_pc,
   output logic [31:0] out_inst,
   input  logic        out_ready,
   output logic        inst_req,
   output logic        inst_wr,
   output logic [1:0]  inst_size,
   output logic [31:0] inst_addr,
   output logic [31:0] inst_wdata,
   input  logic [31:0] inst_rdata,
   input  logic        inst_addr_ok,
   input  logic        inst_data_ok
);

   localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CntW = $clog2(DEPTH) + 1;

   typedef logic [PtrW-1:0] ptr_t;
   typedef logic [CntW-1:0] cnt_t;
   typedef logic [CntW:0]   sum_t;

   localparam sum_t DepthS = sum_t'(DEPTH);

   function automatic ptr_t ptr_inc(input ptr_t p);
      if (p == ptr_t'(DEPTH - 1)) return '0;
      return p + ptr_t'(1);
   endfunction

   logic        run_q;
   logic        hold_q, stale_q;
   logic [31:0] hold_addr_q, fetch_pc_q;
   ptr_t        head_q, tail_q, fill_q;
   cnt_t        occ_q, infl_q, disc_q;
   logic [31:0] pc_q   [DEPTH];
   logic [31:0] inst_q [DEPTH];
   logic        dv_q   [DEPTH];

   logic accept, acc_live, pop, drop, fill;
   sum_t used;

   always_comb begin
      used      = {1'b0, occ_q} + {1'b0, disc_q};
      // A held request stays up regardless of occupancy or redirect.
      inst_req  = run_q & (hold_q | (used < DepthS));
      inst_addr = hold_q ? hold_addr_q : fetch_pc_q;
      accept    = inst_req & inst_addr_ok;
      // Stale = held across a redirect; its data is owed to the discard counter.
      acc_live  = accept & ~stale_q & ~redirect_i;
      out_valid = (occ_q != '0) & dv_q[head_q];
      out_pc    = pc_q[head_q];
      out_inst  = inst_q[head_q];
      pop       = out_valid & out_ready & ~redirect_i;
      drop      = inst_data_ok & (disc_q != '0);
      fill      = inst_data_ok & (disc_q == '0) & (infl_q != '0);
   end

   assign inst_wr    = 1'b0;
   assign inst_size  = 2'b10;
   assign inst_wdata = 32'h0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         run_q       <= 1'b0;
         hold_q      <= 1'b0;
         stale_q     <= 1'b0;
         hold_addr_q <= 32'h0;
         fetch_pc_q  <= RESET_PC;
         head_q      <= '0;
         tail_q      <= '0;
         fill_q      <= '0;
         occ_q       <= '0;
         infl_q      <= '0;
         disc_q      <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            pc_q[i]   <= 32'h0;
            inst_q[i] <= 32'h0;
            dv_q[i]   <= 1'b0;
         end
      end else begin
         run_q       <= 1'b1;
         hold_q      <= inst_req & ~inst_addr_ok;
         stale_q     <= inst_req & ~inst_addr_ok & (redirect_i | stale_q);
         hold_addr_q <= inst_addr;
         if (redirect_i) begin
            fetch_pc_q <= redirect_pc_i;
            head_q     <= '0;
            tail_q     <= '0;
            fill_q     <= '0;
            occ_q      <= '0;
            infl_q     <= '0;
            disc_q     <= disc_q + infl_q + cnt_t'(accept) - cnt_t'(drop | fill);
            for (int i = 0; i < DEPTH; i++) dv_q[i] <= 1'b0;
         end else begin
            if (acc_live) begin
               pc_q[tail_q] <= inst_addr;
               dv_q[tail_q] <= 1'b0;
               tail_q       <= ptr_inc(tail_q);
               fetch_pc_q   <= fetch_pc_q + 32'd4;
            end
            if (fill) begin
               inst_q[fill_q] <= inst_rdata;
               dv_q[fill_q]   <= 1'b1;
               fill_q         <= ptr_inc(fill_q);
            end
            if (pop) head_q <= ptr_inc(head_q);
            occ_q  <= occ_q + cnt_t'(acc_live) - cnt_t'(pop);
            infl_q <= infl_q + cnt_t'(acc_live) - cnt_t'(fill);
            disc_q <= disc_q + cnt_t'(accept & stale_q) - cnt_t'(drop);
         end
      end
   end

   // Data with nothing outstanding is a bus protocol violation.
   a_no_unsolicited_data: assert property (@(posedge clk) disable iff (rst)
      inst_data_ok |-> ((disc_q != '0) || (infl_q != '0)));

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Bench for inst_prefetch_queue: directed scenarios plus random bus/consumer traffic checked
// against a queue-based reference model, run on DEPTH=4 and DEPTH=1 instances.
module tb_inst_prefetch_queue;

   logic        clk = 1'b0;
   logic        rst4, rst1, sel;
   logic        redirect_i, out_ready, inst_addr_ok, inst_data_ok;
   logic [31:0] redirect_pc_i, inst_rdata;

   logic        ov4, req4, wr4, ov1, req1, wr1;
   logic [1:0]  sz4, sz1;
   logic [31:0] pc4, in4, ad4, wd4, pc1, in1, ad1, wd1;

   logic        o_valid, o_req, o_wr;
   logic [1:0]  o_size;
   logic [31:0] o_pc, o_inst, o_addr, o_wdata;

   always #5 clk = ~clk;

   inst_prefetch_queue #(.DEPTH(4), .RESET_PC(32'hbfc00000)) u_dut4 (
      .clk(clk), .rst(rst4), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
      .out_valid(ov4), .out_pc(pc4), .out_inst(in4), .out_ready(out_ready),
      .inst_req(req4), .inst_wr(wr4), .inst_size(sz4), .inst_addr(ad4), .inst_wdata(wd4),
      .inst_rdata(inst_rdata), .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok)
   );

   inst_prefetch_queue #(.DEPTH(1), .RESET_PC(32'hbfc00000)) u_dut1 (
      .clk(clk), .rst(rst1), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
      .out_valid(ov1), .out_pc(pc1), .out_inst(in1), .out_ready(out_ready),
      .inst_req(req1), .inst_wr(wr1), .inst_size(sz1), .inst_addr(ad1), .inst_wdata(wd1),
      .inst_rdata(inst_rdata), .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok)
   );

   assign o_valid = sel ? ov1 : ov4;
   assign o_pc    = sel ? pc1 : pc4;
   assign o_inst  = sel ? in1 : in4;
   assign o_req   = sel ? req1 : req4;
   assign o_wr    = sel ? wr1 : wr4;
   assign o_size  = sel ? sz1 : sz4;
   assign o_addr  = sel ? ad1 : ad4;
   assign o_wdata = sel ? wd1 : wd4;

   // Reference model: reserved entries in order, and bus transactions in order (live or dead).
   typedef struct {logic [31:0] pc; logic [31:0] inst; bit filled;} ent_t;
   typedef struct {logic [31:0] addr; bit live;} bus_t;
   ent_t        q[$];
   bus_t        bus[$];
   int          m_depth;
   bit          m_run, m_hold, m_stale;
   logic [31:0] m_fetch, m_haddr;

   int          n_total = 0, n_pass = 0, n_fail = 0;
   int          seq_k;
   bit          seq_chk = 0;
   logic [31:0] force_rpc = 32'h0;

   function automatic logic [31:0] hash(input logic [31:0] a);
      return {a[7:0], a[31:8]} ^ 32'h13579bdf;
   endfunction

   function automatic bit m_req();
      int dead = 0;
      if (!m_run) return 1'b0;
      if (m_hold) return 1'b1;
      foreach (bus[i]) if (!bus[i].live) dead++;
      return (q.size() + dead) < m_depth;
   endfunction

   function automatic logic [31:0] m_addr();
      return m_hold ? m_haddr : m_fetch;
   endfunction

   function automatic void model_reset();
      q.delete();
      bus.delete();
      m_run = 0; m_hold = 0; m_stale = 0;
      m_fetch = 32'hbfc00000; m_haddr = 32'h0;
      m_depth = sel ? 1 : 4;
   endfunction

   function automatic void model_update();
      bit          req, acc, live, exp_valid;
      logic [31:0] addr;
      bus_t        b;
      req       = m_req();
      addr      = m_addr();
      acc       = req && inst_addr_ok;
      exp_valid = q.size() > 0 && q[0].filled;
      if (exp_valid && out_ready && !redirect_i) void'(q.pop_front());
      if (inst_data_ok && bus.size() > 0) begin
         b = bus.pop_front();
         if (b.live) begin
            for (int i = 0; i < q.size(); i++) begin
               if (!q[i].filled) begin
                  q[i].inst = inst_rdata;
                  q[i].filled = 1;
                  break;
               end
            end
         end
      end
      if (acc) begin
         live = !m_stale && !redirect_i;
         bus.push_back('{addr: addr, live: live});
         if (live) begin
            q.push_back('{pc: addr, inst: 32'h0, filled: 1'b0});
            m_fetch = addr + 32'd4;
         end
      end
      if (redirect_i) begin
         q.delete();
         foreach (bus[i]) bus[i].live = 0;
         m_fetch = redirect_pc_i;
      end
      m_stale = req && !inst_addr_ok && (redirect_i || m_stale);
      m_hold  = req && !inst_addr_ok;
      m_haddr = addr;
      m_run   = 1;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_cycle();
      bit ev;
      ev = q.size() > 0 && q[0].filled;
      chk("inst_req", {31'h0, o_req}, {31'h0, m_req()});
      chk("inst_addr", o_addr, m_addr());
      chk("out_valid", {31'h0, o_valid}, {31'h0, ev});
      if (ev) begin
         chk("out_pc", o_pc, q[0].pc);
         chk("out_inst", o_inst, q[0].inst);
      end
      if (seq_chk && o_valid) begin
         chk("seq_pc", o_pc, 32'hbfc00000 + 32'(4 * seq_k));
         seq_k++;
      end
   endtask

   task automatic drive(input int aok, input int dok, input int rdy, input int rd);
      inst_addr_ok  = ($urandom_range(99) < aok);
      inst_data_ok  = (bus.size() > 0) && ($urandom_range(99) < dok);
      inst_rdata    = inst_data_ok ? hash(bus[0].addr) : $urandom;
      out_ready     = ($urandom_range(99) < rdy);
      redirect_i    = ($urandom_range(99) < rd);
      redirect_pc_i = (force_rpc != 32'h0) ? force_rpc : ($urandom & 32'hfffffffc);
   endtask

   task automatic run_cycles(input int n, input int aok, input int dok, input int rdy,
                             input int rd);
      for (int c = 0; c < n; c++) begin
         drive(aok, dok, rdy, rd);
         @(posedge clk);
         model_update();
         #1;
         check_cycle();
      end
   endtask

   task automatic set_rst(input logic v);
      if (sel) rst1 = v;
      else rst4 = v;
   endtask

   // Reset lands between clock edges; outputs must respond without a clock.
   task automatic do_reset();
      inst_addr_ok = 0; inst_data_ok = 0; redirect_i = 0; out_ready = 0;
      #2;
      set_rst(1'b1);
      #1;
      model_reset();
      chk("rst_req", {31'h0, o_req}, 32'h0);
      chk("rst_valid", {31'h0, o_valid}, 32'h0);
      chk("rst_pc", o_pc, 32'h0);
      chk("rst_inst", o_inst, 32'h0);
      chk("rst_addr", o_addr, 32'hbfc00000);
      chk("rst_wr", {31'h0, o_wr}, 32'h0);
      chk("rst_size", {30'h0, o_size}, 32'h2);
      chk("rst_wdata", o_wdata, 32'h0);
      @(posedge clk);
      @(negedge clk);
      set_rst(1'b0);
   endtask

   task automatic scenarios();
      do_reset();
      run_cycles(1, 0, 0, 0, 0);
      chk("first_req", {31'h0, o_req}, 32'h1);
      chk("first_addr", o_addr, 32'hbfc00000);
      // Zero-wait stream with consumer always ready.
      seq_k = 0; seq_chk = 1;
      run_cycles(12, 100, 100, 100, 0);
      seq_chk = 0;
      chk("seq_count", {31'h0, seq_k >= 3}, 32'h1);
      // Stalled consumer fills the queue, then drains.
      do_reset();
      run_cycles(10, 100, 100, 0, 0);
      chk("full_pc", o_pc, 32'hbfc00000);
      chk("full_valid", {31'h0, o_valid}, 32'h1);
      chk("full_req", {31'h0, o_req}, 32'h0);
      run_cycles(8, 100, 100, 100, 0);
      // Redirect with fetches in flight.
      run_cycles(6, 0, 100, 100, 0);
      run_cycles(3, 100, 0, 0, 0);
      force_rpc = 32'h80001000;
      run_cycles(1, 0, 0, 0, 100);
      force_rpc = 32'h0;
      run_cycles(6, 100, 100, 0, 0);
      chk("redir_valid", {31'h0, o_valid}, 32'h1);
      chk("redir_pc", o_pc, 32'h80001000);
      // Redirect coinciding with accept and data return.
      run_cycles(4, 100, 0, 0, 0);
      run_cycles(1, 100, 100, 100, 100);
      run_cycles(8, 100, 100, 100, 0);
      // Address phase stalled across a redirect.
      run_cycles(2, 0, 100, 100, 0);
      force_rpc = 32'h80002000;
      run_cycles(1, 0, 100, 100, 100);
      force_rpc = 32'h0;
      run_cycles(2, 0, 100, 100, 0);
      run_cycles(8, 100, 100, 100, 0);
      // Random traffic with mid-stream resets.
      run_cycles(200, 80, 60, 70, 5);
      do_reset();
      run_cycles(200, 50, 40, 50, 15);
      run_cycles(100, 100, 100, 100, 25);
      do_reset();
      run_cycles(20, 100, 100, 100, 0);
   endtask

   initial begin
      sel = 0; rst4 = 1; rst1 = 1;
      inst_addr_ok = 0; inst_data_ok = 0; redirect_i = 0; out_ready = 0;
      redirect_pc_i = 32'h0; inst_rdata = 32'h0;
      #12;
      scenarios();
      rst4 = 1;
      sel  = 1;
      @(negedge clk);
      scenarios();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
